// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA data-memory arbiter with a DMA starvation guard and read-return routing.
// Optional macro DMEM_ARB_STALL_CNT_EN adds stall_cnt, a saturating count of CPU stall cycles.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef DMEM_ARB_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD_CPU, RD_DMA} state_t;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    state_t     state_q, state_d;
    logic [7:0] starve_q, starve_d;
    logic       starve_hit;
    // Grants are gated by reset so nothing leaks out while reset is held low.
    always_comb begin
        starve_hit = starve_q == LIMIT;
        cpu_gnt    = reset && cpu_req && !(dma_req && starve_hit);
        dma_gnt    = reset && dma_req && (!cpu_req || starve_hit);
        cpu_stall  = reset && cpu_req && !cpu_gnt;
        mem_en     = cpu_gnt || dma_gnt;
        mem_we     = cpu_gnt ? cpu_we : dma_gnt && dma_we;
        mem_addr   = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
        mem_wdata  = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
        starve_d   = (dma_req && !dma_gnt) ? (starve_hit ? starve_q : starve_q + 8'd1) : 8'd0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
    always_comb begin
        state_d = cpu_gnt && !cpu_we ? RD_CPU : dma_gnt && !dma_we ? RD_DMA : IDLE;
    end
    always_comb begin
        cpu_rvalid = state_q == RD_CPU;
        dma_rvalid = state_q == RD_DMA;
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dma_rdata  = dma_rvalid ? mem_rdata : '0;
    end
`ifdef DMEM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    always_comb begin
        stall_cnt_d = (cpu_stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a read-return scoreboard.
module tb_dmem_arbiter;
    logic        clk, reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int checks = 0;
    int errors = 0;
    typedef struct {logic dma; logic [31:0] data;} exp_t;
    exp_t sb[$];
    exp_t e;
    logic [31:0] mem [64];

    dmem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
`ifdef DMEM_ARB_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Data memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            else mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    always @(posedge clk) begin
        #1;
        if (cpu_rvalid || dma_rvalid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: cpu_rvalid=%b dma_rvalid=%b, required no read return", cpu_rvalid, dma_rvalid);
            end else begin
                e = sb.pop_front();
                if (cpu_rvalid !== !e.dma || dma_rvalid !== e.dma || (e.dma ? dma_rdata : cpu_rdata) !== e.data) begin
                    errors++;
                    $display("FAIL sb_return: cpu_rvalid=%b dma_rvalid=%b cpu_rdata=%h dma_rdata=%h, required dma=%b data=%h",
                             cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, e.dma, e.data);
                end
            end
        end
    end

    task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                          input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(1, i[0], 32'h10, 32'h5, 1, 1, 32'h20, 32'h6);
            #2;
            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_grants: gnt/gnt/stall=%b, required 000", {cpu_gnt, dma_gnt, cpu_stall});
            end
            checks++;
            if ({mem_en, mem_we, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: mem_en=%b mem_we=%b rv=%b%b rdata=%h/%h, required all 0",
                         mem_en, mem_we, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        #2;
        checks++;
        if ({cpu_gnt, dma_gnt, mem_en, cpu_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL idle: gnt/gnt/mem_en/stall=%b, required 0000", {cpu_gnt, dma_gnt, mem_en, cpu_stall});
        end
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        set_in(1, 1, 32'd100, 32'd25, 0, 0, 0, 0);
        #2;
        checks++;
        if ({cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we} !== 5'b10011) begin
            errors++;
            $display("FAIL cpu_write_ctl: gnt/gnt/stall/en/we=%b, required 10011", {cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 32'd100 || mem_wdata !== 32'd25) begin
            errors++;
            $display("FAIL cpu_write_bus: addr=%0d wdata=%0d, required 100/25", mem_addr, mem_wdata);
        end
        @(negedge clk);
        set_in(1, 0, 32'd100, 32'd0, 0, 0, 0, 0);
        sb.push_back('{1'b0, 32'd25});
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        set_in(1, 0, 32'd96, 32'd0, 0, 0, 0, 0);
        #2;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd96) begin
            errors++;
            $display("FAIL cpu_read_bus: en=%b we=%b addr=%0d, required 1/0/96", mem_en, mem_we, mem_addr);
        end
        sb.push_back('{1'b0, 32'd7});
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd7 || dma_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_ret: rvalid=%b rdata=%0d dma_rvalid=%b, required 1/7/0", cpu_rvalid, cpu_rdata, dma_rvalid);
        end
        @(negedge clk);
        #2;
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin
            errors++;
            $display("FAIL cpu_read_after: rvalid=%b rdata=%h, required 0/0", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        logic [15:0] creq = 16'hFFBF;
        logic [15:0] dreq = 16'hFDBF;
        logic [15:0] expc = 16'hBFAF;
        logic [15:0] expd = 16'h4010;
        logic [31:0] ea;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_in(creq[i], 1, 32'h40, 32'hC0, dreq[i], 1, 32'h80, 32'hD0);
            #2;
            ea = expd[i] ? 32'h80 : expc[i] ? 32'h40 : 32'h0;
            checks++;
            if (cpu_gnt !== expc[i] || dma_gnt !== expd[i] || cpu_stall !== expd[i] || mem_addr !== ea) begin
                errors++;
                $display("FAIL starve_cyc%0d: cpu_gnt=%b dma_gnt=%b stall=%b addr=%h, required %b/%b/%b/%h",
                         i, cpu_gnt, dma_gnt, cpu_stall, mem_addr, expc[i], expd[i], expd[i], ea);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_interleaved();
        @(negedge clk);
        set_in(1, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        sb.push_back('{1'b0, 32'h1000});
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 0, 32'd4, 32'd0);
        #2;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1000 || dma_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'd4) begin
            errors++;
            $display("FAIL interleave_c2: rvalid=%b rdata=%h dma_gnt=%b en=%b addr=%h, required 1/1000/1/1/4",
                     cpu_rvalid, cpu_rdata, dma_gnt, mem_en, mem_addr);
        end
        sb.push_back('{1'b1, 32'h1001});
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h1001 || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL interleave_c3: dma_rvalid=%b dma_rdata=%h cpu_rvalid=%b, required 1/1001/0", dma_rvalid, dma_rdata, cpu_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1, 0, 32'(8 + 4 * i), 0, 0, 0, 0, 0);
            sb.push_back('{1'b0, 32'h1000 + 32'(2 + i)});
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 0, 32'd8, 0);
        #1;
        checks++;
        if (dma_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midread_gnt: dma_gnt=%b, required 1", dma_gnt);
        end
        #1 reset = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== '0) begin
                errors++;
                $display("FAIL midread_reset%0d: gnt=%b%b stall=%b en=%b we=%b rv=%b%b, required all 0",
                         i, cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, dma_rvalid);
            end
            @(negedge clk);
            set_in(1, 0, 32'd12, 0, 1, 0, 32'd8, 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #2;
            checks++;
            if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL midread_after%0d: rvalid=%b%b, required 00", i, cpu_rvalid, dma_rvalid);
            end
        end
    endtask

`ifdef DMEM_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_cnt_init: %0d, required 0", stall_cnt);
        end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            set_in(1, 1, 32'h40, 0, 1, 1, 32'h80, 0);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (stall_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stall_cnt_10: %0d, required 10", stall_cnt);
        end
        reset = 0;
        #2;
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_cnt_reset: %0d, required 0", stall_cnt);
        end
        @(negedge clk);
        reset = 1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
        mem[24] = 32'd7;
        mem_rdata = '0;
        reset = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_starvation();
        test_interleaved();
        test_back_to_back();
        test_reset_mid_read();
`ifdef DMEM_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_missing: %0d reads never returned, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width of both requesters and of the memory port.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied DMA cycles before the DMA port gets priority; legal range 1..255.
REQ-003 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Ports cpu_req/cpu_we  in  1/1  CPU access request / write enable.
REQ-006 Ports cpu_addr/cpu_wdata  in  ADDR_W/32  CPU address / CPU store data.
REQ-007 Ports cpu_gnt/cpu_stall/cpu_rvalid  out  1/1/1  CPU access accepted / CPU must hold / CPU read data valid.
REQ-008 Port cpu_rdata  out  32  CPU load data.
REQ-009 Ports dma_req/dma_we/dma_addr/dma_wdata  in  1/1/ADDR_W/32  DMA (program loader) request, write enable, address, data.
REQ-010 Ports dma_gnt/dma_rvalid  out  1/1  DMA access accepted / DMA read data valid.
REQ-011 Port dma_rdata  out  32  DMA read data.
REQ-012 Ports mem_en/mem_we/mem_addr/mem_wdata  out  1/1/ADDR_W/32  data memory access strobe, write enable, address, write data.
REQ-013 Port mem_rdata  in  32  memory read data, valid one cycle after a read strobe.

Function
REQ-014 The arbitration decision SHALL be combinational in the request cycle: cpu_gnt = cpu_req AND NOT (dma_req AND starve_hit); dma_gnt = dma_req AND (NOT cpu_req OR starve_hit).
REQ-015 starve_hit SHALL be 1 when the internal starve counter equals STARVE_LIMIT.
REQ-016 The starve counter SHALL increment each cycle dma_req=1 and dma_gnt=0, saturate at STARVE_LIMIT, and clear when dma_gnt=1 or dma_req=0.
REQ-017 At most one grant SHALL be high per cycle; with no request, both grants and mem_en SHALL be 0.
REQ-018 In a granted cycle, mem_en SHALL be 1, and mem_we/mem_addr/mem_wdata SHALL equal the granted requester's we/addr/wdata in that same cycle.
REQ-019 cpu_stall SHALL equal cpu_req AND NOT cpu_gnt.
REQ-020 A 3-state owner FSM SHALL track the previous cycle's access: IDLE (no access or write), RD_CPU (CPU read granted), RD_DMA (DMA read granted); the next state SHALL be decided by each cycle's grant and we.
REQ-021 In RD_CPU, cpu_rvalid SHALL be 1 with cpu_rdata=mem_rdata; in RD_DMA, dma_rvalid SHALL be 1 with dma_rdata=mem_rdata; otherwise both rvalids SHALL be 0 and both rdata SHALL be 0.
REQ-022 Back-to-back grants SHALL be supported: a new access SHALL issue in the same cycle that the previous read's data returns.
REQ-023 Requesters SHALL hold req/we/addr/wdata stable until granted; the arbiter SHALL NOT register request fields.

Reset
REQ-024 While reset=0, FSM=IDLE, starve counter=0, and cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we, both rvalids and both rdata SHALL be 0, regardless of requests.
REQ-025 Reset asserted mid-read SHALL discard the pending read; no rvalid SHALL be raised after reset deasserts for an access issued before reset.

Configuration
REQ-026 With macro DMEM_ARB_STALL_CNT_EN defined, output stall_cnt (16 bits) SHALL count cycles with cpu_stall=1, saturate at 16'hFFFF, and reset to 0.
REQ-027 Without DMEM_ARB_STALL_CNT_EN, the stall_cnt port and its counter SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-028 CPU alone: cpu_req=1, cpu_we=1, addr=100, wdata=25 -> same cycle cpu_gnt=1, mem_en=1, mem_we=1, mem_addr=100, mem_wdata=25, cpu_stall=0.
REQ-029 CPU read: cpu_req=1, cpu_we=0, addr=96; memory returns 7 -> next cycle cpu_rvalid=1, cpu_rdata=7, dma_rvalid=0.
REQ-030 Starvation: cpu_req and dma_req held high, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA granted in the 5th with cpu_stall=1, then CPU again.
REQ-031 Interleaved reads: CPU read addr 0, then DMA read addr 4 in the next cycle -> cpu_rvalid in cycle 2, dma_rvalid in cycle 3, each with its own data.
REQ-032 Reset mid-read: grant a DMA read, assert reset=0 before the next edge -> dma_rvalid stays 0, all outputs 0 while reset=0.
REQ-033 With DMEM_ARB_STALL_CNT_EN defined: 10 stall cycles -> stall_cnt=10; after reset -> stall_cnt=0.
